// File: rtl/fb_writer_if.sv
// Raster pixel stream into the framebuffer writer: valid/ready with
// start-of-frame and end-of-line markers.
interface fb_writer_if #(
    parameter int p_data_width = 16
) ();
    logic                    valid;
    logic                    ready;
    logic [p_data_width-1:0] data;
    logic                    sof;
    logic                    eol;

    modport master (output valid, data, sof, eol, input ready);
    modport slave  (input valid, data, sof, eol, output ready);
endinterface

// File: rtl/fb_writer.sv
// Double-buffered framebuffer write side: turns a raster pixel stream into
// BRAM writes and swaps banks only after a frame completes cleanly.
module fb_writer #(
    parameter int p_fb_width   = 32,
    parameter int p_fb_height  = 24,
    parameter int p_data_width = 16,
    parameter int p_addr_width = $clog2(2 * p_fb_width * p_fb_height)
) (
    input  logic                    i_clk_pixel,
    input  logic                    i_rst_n,
    fb_writer_if.slave              pix,
    output logic                    o_we,
    output logic [p_addr_width-1:0] o_addr,
    output logic [p_data_width-1:0] o_data,
    output logic                    o_rd_bank,
    output logic                    o_frame_done,
    output logic                    o_err,
    output logic [7:0]              o_err_cnt
);
    localparam int lp_x_w = (p_fb_width  > 1) ? $clog2(p_fb_width)  : 1;
    localparam int lp_y_w = (p_fb_height > 1) ? $clog2(p_fb_height) : 1;
    localparam logic [lp_x_w-1:0] lp_x_last = lp_x_w'(p_fb_width - 1);
    localparam logic [lp_y_w-1:0] lp_y_last = lp_y_w'(p_fb_height - 1);
    localparam logic [p_addr_width-1:0] lp_bank_size = p_addr_width'(p_fb_width * p_fb_height);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_COMMIT} state_t;

    state_t                  state_reg,   state_next;
    logic [lp_x_w-1:0]       x_reg,       x_next;
    logic [lp_y_w-1:0]       y_reg,       y_next;
    logic [p_addr_width-1:0] ptr_reg,     ptr_next;
    logic                    wr_bank_reg, wr_bank_next;
    logic                    rd_bank_reg, rd_bank_next;
    logic                    we_reg,      we_next;
    logic [p_addr_width-1:0] addr_reg,    addr_next;
    logic [p_data_width-1:0] data_reg,    data_next;
    logic                    done_reg,    done_next;
    logic                    err_reg,     err_next;
    logic [7:0]              err_cnt_reg, err_cnt_next;

    logic                    accept;
    logic                    restart;
    logic                    bad_eol;
    logic                    at_x_last;
    logic                    at_y_last;
    logic [lp_x_w-1:0]       cur_x;
    logic [lp_y_w-1:0]       cur_y;
    logic [p_addr_width-1:0] bank_base;
    logic [p_addr_width-1:0] cur_addr;

    assign pix.ready = (state_reg != ST_COMMIT);
    assign accept    = pix.valid && pix.ready;

    // A sof beat always lands at pixel (0,0) of the back bank, whatever the
    // current position; the eol check is then made against that position.
    assign bank_base = wr_bank_reg ? lp_bank_size : '0;
    assign cur_x     = pix.sof ? '0 : x_reg;
    assign cur_y     = pix.sof ? '0 : y_reg;
    assign cur_addr  = pix.sof ? bank_base : ptr_reg;
    assign at_x_last = (cur_x == lp_x_last);
    assign at_y_last = (cur_y == lp_y_last);
    assign bad_eol   = (pix.eol != at_x_last);
    assign restart   = (state_reg == ST_WRITE) && pix.sof && ((x_reg != '0) || (y_reg != '0));

    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        ptr_next     = ptr_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        we_next      = 1'b0;
        addr_next    = addr_reg;
        data_next    = data_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;
        case (state_reg)
            ST_IDLE, ST_WRITE: begin
                if (accept && ((state_reg == ST_WRITE) || pix.sof)) begin
                    we_next   = 1'b1;
                    addr_next = cur_addr;
                    data_next = pix.data;
                    ptr_next  = cur_addr + 1'b1;
                    if (bad_eol) begin
                        state_next = ST_IDLE;
                        x_next     = '0;
                        y_next     = '0;
                    end else if (at_x_last) begin
                        x_next = '0;
                        if (at_y_last) begin
                            state_next = ST_COMMIT;
                            y_next     = '0;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_WRITE;
                            y_next     = cur_y + 1'b1;
                        end
                    end else begin
                        state_next = ST_WRITE;
                        x_next     = cur_x + 1'b1;
                        y_next     = cur_y;
                    end
                    if (bad_eol || restart) begin
                        err_next = 1'b1;
                        if (err_cnt_reg != 8'hff)
                            err_cnt_next = err_cnt_reg + 8'd1;
                    end
                end
            end
            ST_COMMIT: begin
                rd_bank_next = wr_bank_reg;
                wr_bank_next = ~wr_bank_reg;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            ptr_reg     <= '0;
            wr_bank_reg <= 1'b1;
            rd_bank_reg <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            ptr_reg     <= ptr_next;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign o_we         = we_reg;
    assign o_addr       = addr_reg;
    assign o_data       = data_reg;
    assign o_rd_bank    = rd_bank_reg;
    assign o_frame_done = done_reg;
    assign o_err        = err_reg;
    assign o_err_cnt    = err_cnt_reg;
endmodule
